// File: rtl/bob_ind_ctrl.sv
// Allocation, in-order retire and flush sequencer for the BOB indirection store.
// Head/tail carry an extra wrap bit so full and empty stay distinct across wraps.

`ifndef BOB_ADDR_WIDTH
`define BOB_ADDR_WIDTH 6
`endif
`ifndef BOB_COUNT
`define BOB_COUNT 64
`endif

module bob_ind_ctrl #(
  parameter int ADDR_WIDTH = `BOB_ADDR_WIDTH,
  parameter int ADDR_COUNT = `BOB_COUNT,
  parameter int DATA_WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ADDR_WIDTH-1:0] alloc_idx,
  output logic [ADDR_WIDTH:0]   free_cnt,
  input  logic                  flush_valid,
  input  logic [ADDR_WIDTH-1:0] flush_idx,
  input  logic                  flush_all,
  output logic                  ram_read_clkEn,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_read_ready,
  output logic [ADDR_WIDTH-1:0] ram_writeI_addr,
  output logic                  ram_writeI_ready,
  output logic                  ram_writeI_wen,
  output logic                  ret_valid,
  input  logic                  ret_ready,
  output logic [ADDR_WIDTH-1:0] ret_idx,
  output logic [DATA_WIDTH-1:0] ret_data,
  output logic                  busy
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH:0]   PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ADDR_COUNT-1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   head_q, head_d;
  logic [ADDR_WIDTH:0]   tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [ADDR_WIDTH:0]   count, keep;
  logic                  running, empty, full, ret_fire;

  always_comb begin
    count     = tail_q - head_q;
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    running   = (state_q == RUN) && !rst;
    ret_valid = running && !empty && ram_read_ready;
    ret_fire  = ret_valid && ret_ready;
    alloc_gnt = running && alloc_req && !full && !flush_valid && !flush_all;
    head_d    = ret_fire ? head_q + PTR_ONE : head_q;
    // Entries kept by a partial flush, measured from the pre-retire head.
    keep      = {1'b0, flush_idx - head_q[ADDR_WIDTH-1:0]} + PTR_ONE;
  end

  assign alloc_idx        = tail_q[ADDR_WIDTH-1:0];
  assign free_cnt         = FULL_CNT - count;
  assign ram_read_clkEn   = 1'b1;
  assign ram_read_addr    = head_d[ADDR_WIDTH-1:0];
  assign ram_writeI_ready = 1'b0;
  assign ret_idx          = head_q[ADDR_WIDTH-1:0];
  assign ret_data         = ram_read_data;

  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    tail_d          = tail_q;
    busy            = rst;
    ram_writeI_wen  = 1'b0;
    ram_writeI_addr = tail_q[ADDR_WIDTH-1:0];
    unique case (state_q)
      INIT: begin
        busy            = 1'b1;
        ram_writeI_wen  = !rst;
        ram_writeI_addr = sweep_q;
        sweep_d         = sweep_q + IDX_ONE;
        if (sweep_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ram_writeI_wen = alloc_gnt;
        if (flush_all) begin
          tail_d = head_d;
        end else if (flush_valid) begin
          if (keep <= count) begin
            tail_d = head_q + keep;
          end
        end else if (alloc_gnt) begin
          tail_d = tail_q + PTR_ONE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      sweep_q <= sweep_d;
    end
  end

endmodule

// File: tb/tb_bob_ind_ctrl.sv
// Randomized and directed bench for bob_ind_ctrl with a behavioural store and
// an in-order retire scoreboard driven by a list of live entries.

module tb_bob_ind_ctrl;

  localparam int AW = 6;
  localparam int N  = 64;
  localparam int DW = 65;
  localparam bit H  = 1'b1;
  localparam bit L  = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req, alloc_gnt;
  logic [AW-1:0] alloc_idx;
  logic [AW:0]   free_cnt;
  logic          flush_valid, flush_all;
  logic [AW-1:0] flush_idx;
  logic          ram_read_clkEn;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data;
  logic          ram_read_ready;
  logic [AW-1:0] ram_writeI_addr;
  logic          ram_writeI_ready, ram_writeI_wen;
  logic          ret_valid, ret_ready;
  logic [AW-1:0] ret_idx;
  logic [DW-1:0] ret_data;
  logic          busy;

  always #5 clk = ~clk;

  bob_ind_ctrl #(.ADDR_WIDTH(AW), .ADDR_COUNT(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .free_cnt(free_cnt),
    .flush_valid(flush_valid), .flush_idx(flush_idx), .flush_all(flush_all),
    .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .ram_read_ready(ram_read_ready),
    .ram_writeI_addr(ram_writeI_addr), .ram_writeI_ready(ram_writeI_ready),
    .ram_writeI_wen(ram_writeI_wen),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_idx(ret_idx), .ret_data(ret_data),
    .busy(busy)
  );

  // Behavioural store: registered read address, invalidate port and completion port.
  logic [DW-1:0] st_data [N];
  logic          st_rdy  [N];
  logic [AW-1:0] st_addr_q;
  logic          cmp_en;
  logic [AW-1:0] cmp_idx;
  logic [DW-1:0] cmp_data;

  assign ram_read_data  = st_data[st_addr_q];
  assign ram_read_ready = st_rdy[st_addr_q];

  always @(posedge clk) begin
    if (ram_read_clkEn) st_addr_q <= ram_read_addr;
    if (ram_writeI_wen) st_rdy[ram_writeI_addr] <= ram_writeI_ready;
    if (cmp_en) begin
      st_rdy[cmp_idx]  <= 1'b1;
      st_data[cmp_idx] <= cmp_data;
    end
  end

  // Reference model: unbounded head/tail counters and the list of live entries.
  int            total = 0;
  int            bad = 0;
  int            mh = 0;
  int            mt = 0;
  int            init_cnt = 0;
  logic [AW-1:0] sb_q [$];
  bit            done [N];
  logic [DW-1:0] exp_data [N];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retire monitor: pops the oldest live entry whenever the DUT hands one over.
  always @(negedge clk) begin
    logic [AW-1:0] exp_idx;
    #3;
    if (ret_valid === 1'b1 && ret_ready === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL retire_unexpected actual idx=%0d expected none", ret_idx);
      end else begin
        exp_idx = sb_q.pop_front();
        mh++;
        if (ret_idx !== exp_idx) begin
          bad++;
          $display("[TB] FAIL retire_idx actual=%0d expected=%0d", ret_idx, exp_idx);
        end
        total++;
        if (ret_data !== exp_data[exp_idx]) begin
          bad++;
          $display("[TB] FAIL retire_data actual=%h expected=%h", ret_data, exp_data[exp_idx]);
        end
      end
    end
  end

  task automatic checkOutput(input logic r, areq, fv, fa, output bit exp_gnt);
    bit running, exp_rv, exp_wen;
    running = !r && (init_cnt >= N);
    exp_gnt = running && areq && ((mt - mh) < N) && !fv && !fa;
    exp_rv  = running && (sb_q.size() > 0) && done[sb_q[0]];
    exp_wen = r ? 1'b0 : ((init_cnt < N) ? 1'b1 : exp_gnt);
    check_val("busy", 64'(busy), 64'(!running));
    check_val("alloc_gnt", 64'(alloc_gnt), 64'(exp_gnt));
    check_val("ret_valid", 64'(ret_valid), 64'(exp_rv));
    check_val("writeI_wen", 64'(ram_writeI_wen), 64'(exp_wen));
    check_val("writeI_ready", 64'(ram_writeI_ready), 64'd0);
    check_val("read_clkEn", 64'(ram_read_clkEn), 64'd1);
    check_val("free_cnt", 64'(free_cnt), 64'(N - (mt - mh)));
    if (exp_wen)
      check_val("writeI_addr", 64'(ram_writeI_addr), 64'((init_cnt < N) ? init_cnt : mt % N));
    if (running) check_val("alloc_idx", 64'(alloc_idx), 64'(mt % N));
    if (exp_rv) check_val("ret_idx", 64'(ret_idx), 64'(mh % N));
  endtask

  task automatic applyStimulus(input logic r, areq, fv, fa, input logic [AW-1:0] fi,
                               input logic rr, ce, input logic [AW-1:0] ci);
    bit exp_gnt;
    int hp, cp, keep;
    @(negedge clk);
    rst = r; alloc_req = areq; flush_valid = fv; flush_all = fa; flush_idx = fi;
    ret_ready = rr; cmp_en = ce; cmp_idx = ci;
    cmp_data[31:0] = $urandom; cmp_data[63:32] = $urandom; cmp_data[64] = 1'($urandom);
    #2;
    checkOutput(r, areq, fv, fa, exp_gnt);
    hp = mh;
    cp = mt - mh;
    #2;
    if (r) begin
      init_cnt = 0; mh = 0; mt = 0; sb_q.delete();
      foreach (done[k]) done[k] = 1'b0;
    end else if (init_cnt < N) begin
      init_cnt++;
    end else begin
      if (fa) begin
        mt = mh;
        sb_q.delete();
      end else if (fv) begin
        keep = ((int'(fi) - hp) % N + N) % N + 1;
        if (keep <= cp) begin
          mt = hp + keep;
          while (sb_q.size() > mt - mh) void'(sb_q.pop_back());
        end
      end else if (exp_gnt) begin
        sb_q.push_back(AW'(mt % N));
        done[mt % N] = 1'b0;
        mt++;
      end
      if (ce) begin
        done[ci] = 1'b1;
        exp_data[ci] = cmp_data;
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(L, L, L, L, '0, rr, L, '0);
  endtask

  task automatic reset_and_sweep();
    applyStimulus(H, L, L, L, '0, L, L, '0);
    applyStimulus(H, L, L, L, '0, L, L, '0);
    idle(N + 1, L);
  endtask

  task automatic drain();
    logic [AW-1:0] live [$];
    live = sb_q;
    foreach (live[k]) begin
      if (!done[live[k]]) applyStimulus(L, L, L, L, '0, H, H, live[k]);
      else idle(1, H);
    end
    idle(3, H);
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; flush_valid = 1'b0; flush_all = 1'b0; flush_idx = '0;
    ret_ready = 1'b0; cmp_en = 1'b0; cmp_idx = '0; cmp_data = '0; st_addr_q = '0;
    foreach (st_rdy[k]) begin
      st_rdy[k] = 1'b0; st_data[k] = '0; done[k] = 1'b0; exp_data[k] = '0;
    end

    // Post-reset sweep, then out-of-order completion with in-order retire.
    reset_and_sweep();
    for (int i = 0; i < 3; i++) applyStimulus(L, H, L, L, '0, H, L, '0);
    applyStimulus(L, L, L, L, '0, H, H, 6'd1);
    idle(2, H);
    applyStimulus(L, L, L, L, '0, H, H, 6'd0);
    idle(3, H);
    applyStimulus(L, L, L, L, '0, H, H, 6'd2);
    idle(2, H);

    // Fill to full, refuse the extra request, retire one and reuse the wrapped slot.
    reset_and_sweep();
    for (int i = 0; i < N + 1; i++) applyStimulus(L, H, L, L, '0, L, L, '0);
    applyStimulus(L, L, L, L, '0, L, H, 6'd0);
    applyStimulus(L, L, L, L, '0, H, L, '0);
    applyStimulus(L, H, L, L, '0, L, L, '0);
    applyStimulus(L, H, L, L, '0, L, L, '0);
    drain();

    // Partial flush, out-of-range flush, then flush_all with a same-cycle retire.
    reset_and_sweep();
    for (int i = 0; i < 13; i++) applyStimulus(L, H, L, L, '0, L, L, '0);
    for (int i = 0; i < 5; i++) applyStimulus(L, L, L, L, '0, H, H, AW'(i));
    idle(2, H);
    applyStimulus(L, H, H, L, 6'd8, L, L, '0);
    for (int i = 0; i < 4; i++) applyStimulus(L, H, L, L, '0, L, L, '0);
    applyStimulus(L, L, H, L, 6'd20, L, L, '0);
    applyStimulus(L, L, L, L, '0, L, H, 6'd5);
    applyStimulus(L, L, L, H, '0, H, L, '0);
    idle(2, H);

    // Reset in the middle of the sweep restarts it from address 0.
    applyStimulus(H, L, L, L, '0, L, L, '0);
    idle(30, L);
    applyStimulus(H, L, L, L, '0, L, L, '0);
    idle(N + 1, L);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int pick [$];
      logic ce;
      logic [AW-1:0] ci, fi;
      pick.delete();
      foreach (sb_q[k]) if (!done[sb_q[k]]) pick.push_back(k);
      ce = (pick.size() > 0) && ($urandom_range(0, 99) < 45);
      ci = ce ? sb_q[pick[$urandom_range(0, pick.size() - 1)]] : '0;
      fi = AW'(mh + int'($urandom_range(0, 70)));
      applyStimulus(L, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 199) < 2, fi, $urandom_range(0, 99) < 60, ce, ci);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bob_ind_ctrl.md
Name: bob_ind_ctrl

Overview:
Allocation, retire and flush sequencer for the BOB indirection store, which holds 65-bit entries with a per-entry ready bit. It manages the store as a circular buffer. Producers allocate entries in order at the tail, and the controller clears each entry's ready bit through the store's invalidate port. Completion units write entry data and set ready directly. The controller reads the head entry every cycle and retires it in order to the consumer through a valid/ready handshake. It also performs a post-reset ready-bit sweep and supports partial flush on mispredict.

Parameters:
ADDR_WIDTH, `bob_addr_width, entry index width
ADDR_COUNT, `bob_count, number of entries; must equal 2**ADDR_WIDTH
DATA_WIDTH, 65, entry payload width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_req  in  1  request one new entry this cycle
alloc_gnt  out  1  entry granted this cycle
alloc_idx  out  ADDR_WIDTH  index of granted entry, equal to the tail
free_cnt  out  ADDR_WIDTH+1  number of free entries
flush_valid  in  1  partial flush request
flush_idx  in  ADDR_WIDTH  youngest entry to keep
flush_all  in  1  discard all entries; has priority over flush_valid
ram_read_clkEn  out  1  store read-address enable
ram_read_addr  out  ADDR_WIDTH  store read address, registered inside the store
ram_read_data  in  DATA_WIDTH  store data at the registered address
ram_read_ready  in  1  store ready bit at the registered address
ram_writeI_addr  out  ADDR_WIDTH  invalidate-port address
ram_writeI_ready  out  1  invalidate-port value; always 0
ram_writeI_wen  out  1  invalidate-port write enable
ret_valid  out  1  head entry valid for retire
ret_ready  in  1  consumer accepts the head entry
ret_idx  out  ADDR_WIDTH  index of the head entry
ret_data  out  DATA_WIDTH  payload of the head entry
busy  out  1  sweep in progress

Behaviour:
- State: head and tail pointers, each ADDR_WIDTH+1 bits including a wrap bit.
  - count = tail - head, modulo 2**(ADDR_WIDTH+1).
  - empty when count == 0; full when count == ADDR_COUNT.
  - free_cnt = ADDR_COUNT - count.
- FSM states: INIT, RUN.
- Reset (rst=1):
  - head = tail = 0; sweep counter = 0; state = INIT.
  - Output values during reset: alloc_gnt=0, ret_valid=0, busy=1, ram_writeI_wen=0.
- INIT sweep:
  - Each cycle: ram_writeI_wen=1, ram_writeI_addr = sweep counter, then counter increments.
  - After writing entry ADDR_COUNT-1, move to RUN. The sweep therefore lasts exactly ADDR_COUNT cycles.
  - busy=1, alloc_gnt=0, ret_valid=0 throughout.
  - Flush inputs are ignored.
  - rst asserted mid-sweep restarts the sweep at 0.
- RUN, allocation:
  - alloc_gnt = alloc_req & !full & !flush_valid & !flush_all.
  - alloc_idx = tail[ADDR_WIDTH-1:0], driven combinationally.
  - On grant, in the same cycle: ram_writeI_wen=1 and ram_writeI_addr = alloc_idx; tail increments at the clock edge.
  - At most one allocation per cycle.
- RUN, read:
  - ram_read_clkEn = 1 always.
  - ram_read_addr = next-cycle head, i.e. head+1 if retiring this cycle, otherwise head.
  - Consequence: the registered store address always equals head, and retire has no bubble between consecutive entries.
- RUN, retire:
  - ret_valid = !empty & ram_read_ready & (state==RUN).
  - ret_idx = head; ret_data = ram_read_data.
  - On ret_valid & ret_ready, head increments.
  - An entry allocated in cycle N cannot be retired before cycle N+1. Its ready bit reads 0 from N+1 until a completion write sets it.
- Wrap-around: pointer index bits wrap modulo ADDR_COUNT; the wrap bit toggles on wrap. Full and empty must be distinguished correctly after any number of wraps.
- flush_all:
  - tail <= head after applying any same-cycle retire, so the buffer ends empty.
  - Allocation is blocked that cycle.
- flush_valid (flush_all=0):
  - keep = ((flush_idx - head[ADDR_WIDTH-1:0]) mod ADDR_COUNT) + 1, computed against the pre-retire head.
  - New tail = head + keep, using the pre-retire head.
  - If keep > count, the flush is ignored and tail is unchanged.
  - A same-cycle retire still advances head.
  - Allocation is blocked that cycle.
- Completion writes to discarded entries are upstream's responsibility. Re-allocation clears ready, so a stale ready bit is never observed while the entry is the live head.

Test Plan:
- Reset, then 64 cycles → ram_writeI_wen high for addresses 0..63 in order; busy falls at cycle 64; free_cnt=64.
- Allocate 3 entries (idx 0,1,2), complete idx 1 only → ret_valid stays 0; after completing idx 0, ret_idx=0 retires, then stalls on idx 1 until its data… idx 1 retires next cycle with no bubble, then stall on idx 2.
- Allocate 64 entries → full, 65th alloc_req gets alloc_gnt=0; retire one, then allocate → alloc_idx=0 with the wrap bit set; free_cnt tracks 0→1→0.
- Entries 5..12 live (head=5, tail=13), flush_valid with flush_idx=8 → tail=9, free_cnt=60; a same-cycle alloc_req is refused.
- flush_valid with flush_idx=20 while head=5, tail=13 → ignored; then flush_all with a simultaneous retire of entry 5 → head=tail=6, ret_valid=0.
- rst asserted at sweep cycle 30 → sweep restarts at address 0 and busy stays high for 64 further cycles.
